// File: rtl/start_anim_pkg.sv
// start_anim_pkg: shared types and geometry for the animated start screen.
// Holds FSM states, ship region codes, base colours and ship box bounds.
package start_anim_pkg;

    typedef enum logic [1:0] {
        FADE_IN,
        SAIL,
        FADE_OUT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        REG_WHITE,
        REG_GRAY1,
        REG_GRAY2,
        REG_BLACK
    } region_t;

    // 4-bit base colours; the renderer left-justifies them to COLOR_W.
    localparam logic [3:0] WHITE = 4'hD;
    localparam logic [3:0] GRAY1 = 4'h6;
    localparam logic [3:0] GRAY2 = 4'h3;
    localparam logic [3:0] BLACK = 4'h0;

    // Ship bounding box, relative to its top-left corner.
    localparam int BOX_W = 448;
    localparam int BOX_H = 161;

    // Mast / tower.
    localparam int TOWER_Y1 = 31;
    localparam int TOWER_X0 = 161;
    localparam int TOWER_X1 = 255;

    // Bridge.
    localparam int BRIDGE_Y0 = 32;
    localparam int BRIDGE_Y1 = 63;
    localparam int BRIDGE_X0 = 161;
    localparam int BRIDGE_X1 = 319;

    // Upper deck.
    localparam int DECK1_Y0 = 64;
    localparam int DECK1_Y1 = 79;
    localparam int DECK1_X0 = 129;
    localparam int DECK1_X1 = 319;

    // Lower deck.
    localparam int DECK2_Y0 = 80;
    localparam int DECK2_Y1 = 95;
    localparam int DECK2_X0 = 129;
    localparam int DECK2_X1 = 383;

    // Hull is a trapezoid: bow edge rx >= ry/2-48, stern edge rx < 496-ry/2.
    localparam int HULL_Y0    = 96;
    localparam int HULL_Y1    = 160;
    localparam int HULL_BOW   = 48;
    localparam int HULL_STERN = 496;

`ifdef DISPLAY_START_BLINK_EN
    // Prompt bar, relative to a fixed origin at H_ACT_START+BAR_ORG.
    localparam int BAR_ORG  = 256;
    localparam int BAR_Y0   = 176;
    localparam int BAR_Y1   = 191;
    localparam int BAR_X0   = 160;
    localparam int BAR_X1   = 287;
    localparam int BLINK_W  = 5;
`endif

    function automatic logic [3:0] base_of(region_t r);
        logic [3:0] c;
        unique case (r)
            REG_GRAY1: c = GRAY1;
            REG_GRAY2: c = GRAY2;
            REG_BLACK: c = BLACK;
            default:   c = WHITE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/start_ship_shape.sv
// start_ship_shape: combinational classifier of a ship-relative pixel.
// Ports: rx, ry (signed, relative to box corner) in; region code out.
module start_ship_shape
    import start_anim_pkg::*;
#(
    parameter int W = 18
) (
    input  logic signed [W-1:0] rx,
    input  logic signed [W-1:0] ry,
    output region_t             region
);

    logic signed [W-1:0] half_ry;
    logic                in_box;
    logic                tower;
    logic                bridge;
    logic                deck1;
    logic                deck2;
    logic                hull;

    function automatic logic in_rng(
        input logic signed [W-1:0] v,
        input int                  lo,
        input int                  hi
    );
        return (v >= $signed(W'(lo))) && (v <= $signed(W'(hi)));
    endfunction

    always_comb begin
        // ry is non-negative whenever hull is evaluated, so >>> truncates.
        half_ry = ry >>> 1;
        in_box  = in_rng(rx, 0, BOX_W - 1) && in_rng(ry, 0, BOX_H - 1);

        tower  = in_rng(ry, 0, TOWER_Y1)
              && in_rng(rx, TOWER_X0, TOWER_X1);
        bridge = in_rng(ry, BRIDGE_Y0, BRIDGE_Y1)
              && in_rng(rx, BRIDGE_X0, BRIDGE_X1);
        deck1  = in_rng(ry, DECK1_Y0, DECK1_Y1)
              && in_rng(rx, DECK1_X0, DECK1_X1);
        deck2  = in_rng(ry, DECK2_Y0, DECK2_Y1)
              && in_rng(rx, DECK2_X0, DECK2_X1);
        hull   = in_rng(ry, HULL_Y0, HULL_Y1)
              && (rx >= half_ry - $signed(W'(HULL_BOW)))
              && (rx <  $signed(W'(HULL_STERN)) - half_ry);

        region = REG_WHITE;
        if (in_box) begin
            // Row bands are disjoint, so at most one term is true.
            unique case (1'b1)
                tower:   region = REG_GRAY1;
                bridge:  region = REG_GRAY1;
                deck1:   region = REG_GRAY2;
                deck2:   region = REG_GRAY2;
                hull:    region = REG_BLACK;
                default: region = REG_WHITE;
            endcase
        end
    end

endmodule

// File: rtl/display_start_anim.sv
// display_start_anim: animated start screen (fade in, sail, fade out).
// Ports: clk, rst_n, pix_en, en, h_cnt, v_cnt, start_req in;
//        done, busy, red, green, blue out (colour registered on pix_en).
// Optional macro DISPLAY_START_BLINK_EN adds a blinking prompt bar in SAIL.
module display_start_anim
    import start_anim_pkg::*;
#(
    parameter int CNT_W            = 16,
    parameter int COLOR_W          = 4,
    parameter int H_ACT_START      = 144,
    parameter int H_ACT_END        = 783,
    parameter int V_ACT_START      = 35,
    parameter int V_ACT_END        = 514,
    parameter int SHIP_Y           = 195,
    parameter int SHIP_SPEED       = 2,
    parameter int FADE_STEP_FRAMES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    input  logic               en,
    input  logic [CNT_W-1:0]   h_cnt,
    input  logic [CNT_W-1:0]   v_cnt,
    input  logic               start_req,
    output logic               done,
    output logic               busy,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);

    localparam int LW = COLOR_W + 1;
    localparam int RW = CNT_W + 2;
    localparam int PW = 2 * COLOR_W + 1;
    localparam int SW = (FADE_STEP_FRAMES > 1)
                      ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam int SAIL_LIMIT = (H_ACT_END - H_ACT_START + 1) - BOX_W;

    localparam logic [LW-1:0]  LVL_MAX   = LW'(1 << COLOR_W);
    localparam logic [SW-1:0]  STEP_LAST = SW'(FADE_STEP_FRAMES - 1);
    localparam logic [CNT_W:0] SHIP_STEP = (CNT_W + 1)'(SHIP_SPEED);
    localparam logic [CNT_W:0] SHIP_LIM  = (CNT_W + 1)'(SAIL_LIMIT);

    state_t             state;
    state_t             state_nx;
    logic [LW-1:0]      level;
    logic [LW-1:0]      level_nx;
    logic [CNT_W-1:0]   ship_x;
    logic [CNT_W-1:0]   ship_nx;
    logic [SW-1:0]      step_cnt;
    logic [SW-1:0]      step_nx;
    logic               step_wrap;
    logic               frame_tick;

    logic               active;
    logic signed [RW-1:0] rx;
    logic signed [RW-1:0] ry;
    region_t            region;
    logic [3:0]         base;
    logic [COLOR_W-1:0] base_s;
    logic [PW-1:0]      prod;
    logic [COLOR_W-1:0] shade;
    logic [COLOR_W-1:0] shade_q;

`ifdef DISPLAY_START_BLINK_EN
    logic [BLINK_W-1:0]   blink_cnt;
    logic [BLINK_W-1:0]   blink_nx;
    logic signed [RW-1:0] bar_rx;
    logic                 bar_hit;
`endif

    assign frame_tick = pix_en && (h_cnt == '0) && (v_cnt == '0);

    // ---------------- next-state ----------------
    always_comb begin
        state_nx  = state;
        level_nx  = level;
        ship_nx   = ship_x;
        step_nx   = step_cnt;
        step_wrap = (step_cnt == STEP_LAST);
        if (pix_en) begin
            unique case (state)
                FADE_IN: begin
                    // start_req beats the SAIL hand-off on the same tick.
                    if (start_req) begin
                        state_nx = FADE_OUT;
                    end else if (frame_tick) begin
                        if (step_wrap) begin
                            step_nx  = '0;
                            level_nx = level + 1'b1;
                            if (level_nx == LVL_MAX) begin
                                state_nx = SAIL;
                            end
                        end else begin
                            step_nx = step_cnt + 1'b1;
                        end
                    end
                end
                SAIL: begin
                    if (start_req) begin
                        state_nx = FADE_OUT;
                    end else if (frame_tick) begin
                        // Wrap before the box could run past the right edge.
                        if ({1'b0, ship_x} + SHIP_STEP >= SHIP_LIM) begin
                            ship_nx = '0;
                        end else begin
                            ship_nx = ship_x + CNT_W'(SHIP_SPEED);
                        end
                    end
                end
                FADE_OUT: begin
                    if (frame_tick) begin
                        if (level == '0) begin
                            state_nx = DONE;
                        end else if (step_wrap) begin
                            step_nx  = '0;
                            level_nx = level - 1'b1;
                            if (level == LW'(1)) begin
                                state_nx = DONE;
                            end
                        end else begin
                            step_nx = step_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

`ifdef DISPLAY_START_BLINK_EN
    always_comb begin
        blink_nx = blink_cnt;
        if (state_nx == SAIL && state != SAIL) begin
            blink_nx = '0;
        end else if (state == SAIL && frame_tick) begin
            blink_nx = blink_cnt + 1'b1;
        end
    end
`endif

    // ---------------- geometry ----------------
    assign rx = $signed({2'b00, h_cnt})
              - $signed(RW'(H_ACT_START))
              - $signed({2'b00, ship_x});
    assign ry = $signed({2'b00, v_cnt})
              - $signed(RW'(SHIP_Y));

    start_ship_shape #(
        .W (RW)
    ) u_shape (
        .rx     (rx),
        .ry     (ry),
        .region (region)
    );

`ifdef DISPLAY_START_BLINK_EN
    assign bar_rx = $signed({2'b00, h_cnt})
                  - $signed(RW'(H_ACT_START + BAR_ORG));
    assign bar_hit = (bar_rx >= $signed(RW'(BAR_X0)))
                  && (bar_rx <= $signed(RW'(BAR_X1)))
                  && (ry >= $signed(RW'(BAR_Y0)))
                  && (ry <= $signed(RW'(BAR_Y1)));
`endif

    // ---------------- colour and fade ----------------
    always_comb begin
        active = (h_cnt >= CNT_W'(H_ACT_START))
              && (h_cnt <= CNT_W'(H_ACT_END))
              && (v_cnt >= CNT_W'(V_ACT_START))
              && (v_cnt <= CNT_W'(V_ACT_END));
        base = base_of(region);
`ifdef DISPLAY_START_BLINK_EN
        if (state == SAIL && bar_hit && !blink_cnt[BLINK_W-1]) begin
            base = GRAY2;
        end
`endif
        // Left-justify the 4-bit base into COLOR_W bits.
        base_s = COLOR_W'({base, {COLOR_W{1'b0}}} >> 4);
        // Full-width product so the shift drops only fraction bits.
        prod   = PW'(base_s) * PW'(level);
        shade  = COLOR_W'(prod >> COLOR_W);
    end

    // ---------------- state and pixel register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FADE_IN;
            level    <= '0;
            ship_x   <= '0;
            step_cnt <= '0;
            shade_q  <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else if (!en) begin
            state    <= FADE_IN;
            level    <= '0;
            ship_x   <= '0;
            step_cnt <= '0;
            shade_q  <= '0;
            done     <= 1'b0;
            busy     <= 1'b1;
        end else begin
            state    <= state_nx;
            level    <= level_nx;
            ship_x   <= ship_nx;
            step_cnt <= step_nx;
            done     <= (state_nx == DONE) && (state != DONE);
            busy     <= (state_nx != DONE);
            if (pix_en) begin
                shade_q <= (active && state != DONE) ? shade : '0;
            end
        end
    end

`ifdef DISPLAY_START_BLINK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
        end else if (!en) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_nx;
        end
    end
`endif

    assign red   = shade_q;
    assign green = shade_q;
    assign blue  = shade_q;

endmodule
